cu_xb_pipe: RTL

Parametrised successor to the compute-unit/register-file crossbar. It arbitrates write-back from NUM_UNITS compute units plus the broadcast path. The selected result is registered into a one-cycle write-back stage that drives the register file. Both read ports get two-level forwarding (current-cycle result, then in-flight write-back stage) ahead of register-file data. It also detects multi-source write collisions and counts them, with a saturating counter and a sticky flag.

---
 rtl/cu_xb_pkg.sv | 14 +
 rtl/xb_fwd_mux.sv | 38 +++
 rtl/cu_xb_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cu_xb_pkg.sv
// Shared constants for the compute-unit / register-file crossbar.
// Holds the unit index map and the default widths.
package cu_xb_pkg;

    localparam int CU_ALU = 0;
    localparam int CU_MUL = 1;
    localparam int CU_SHF = 2;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_ADDRESS_WIDTH = 4;
    localparam int DEF_NUM_UNITS     = 3;
    localparam int DEF_ERR_CNT_WIDTH = 8;

endpackage

// File: rtl/xb_fwd_mux.sv
// One read port's operand forwarding: the current-cycle result has priority,
// then the in-flight write-back stage, then register-file data.
module xb_fwd_mux #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 4,
    parameter bit FWD_EN        = 1'b1
) (
    input  logic [ADDRESS_WIDTH-1:0] raddr_i,
    input  logic                     s0_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] s0_wadd_i,
    input  logic [DATA_WIDTH-1:0]    s0_dt_i,
    input  logic                     s1_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] s1_wadd_i,
    input  logic [DATA_WIDTH-1:0]    s1_dt_i,
    input  logic [DATA_WIDTH-1:0]    rf_dt_i,
    output logic [DATA_WIDTH-1:0]    dt_o
);

    generate
        if (FWD_EN) begin : g_fwd
            always_comb begin
                dt_o = rf_dt_i;
                if (s0_valid_i && (raddr_i == s0_wadd_i)) begin
                    dt_o = s0_dt_i;
                end else if (s1_valid_i && (raddr_i == s1_wadd_i)) begin
                    dt_o = s1_dt_i;
                end
            end
        end else begin : g_nofwd
            // Forwarding inputs are intentionally ignored in this build.
            logic unused_fwd;
            assign unused_fwd = ^{raddr_i, s0_valid_i, s0_wadd_i, s0_dt_i,
                                  s1_valid_i, s1_wadd_i, s1_dt_i};
            assign dt_o = rf_dt_i;
        end
    endgenerate

endmodule

// File: rtl/cu_xb_pipe.sv
// Write-back crossbar: priority-selects one result per cycle, registers it
// into a write-back stage, forwards to both read ports, and tracks collisions.
module cu_xb_pipe
    import cu_xb_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_UNITS     = DEF_NUM_UNITS,
    parameter bit FWD_EN        = 1'b1,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_UNITS-1:0]            ps_xb_w_cuEn,
    input  logic                            ps_xb_w_bcEn,
    input  logic [ADDRESS_WIDTH-1:0]        ps_xb_wadd,
    input  logic [ADDRESS_WIDTH-1:0]        ps_xb_raddx,
    input  logic [ADDRESS_WIDTH-1:0]        ps_xb_raddy,
    input  logic [DATA_WIDTH-1:0]           bc_dt,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] cu_xb_dt,
    input  logic [DATA_WIDTH-1:0]           rf_xb_dtx,
    input  logic [DATA_WIDTH-1:0]           rf_xb_dty,
    input  logic                            err_clr,
    output logic [DATA_WIDTH-1:0]           xb_dtx,
    output logic [DATA_WIDTH-1:0]           xb_dty,
    output logic                            xb_rf_w_En,
    output logic [ADDRESS_WIDTH-1:0]        xb_rf_wadd,
    output logic [DATA_WIDTH-1:0]           xb_rf_dt,
    output logic                            xb_coll,
    output logic                            xb_coll_sticky,
    output logic [ERR_CNT_WIDTH-1:0]        xb_coll_cnt
);

    localparam int REQ_W = NUM_UNITS + 1;

    // Bit 0 is unit 0 (highest priority); the broadcast sits in the top bit.
    function automatic logic [REQ_W-1:0] first_grant(input logic [REQ_W-1:0] v);
        return v & (~v + REQ_W'(1));
    endfunction

    logic [REQ_W-1:0]         req;
    logic [REQ_W-1:0]         grant;
    logic                     s0_valid;
    logic                     collision;
    logic [DATA_WIDTH-1:0]    s0_dt;
    logic [ADDRESS_WIDTH-1:0] s0_wadd;

    assign req       = {ps_xb_w_bcEn, ps_xb_w_cuEn};
    assign grant     = first_grant(req);
    assign s0_valid  = |req;
    assign collision = |(req & (req - REQ_W'(1)));
    assign s0_wadd   = ps_xb_wadd;

    always_comb begin
        s0_dt = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) begin
                s0_dt = s0_dt | cu_xb_dt[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (grant[NUM_UNITS]) begin
            s0_dt = s0_dt | bc_dt;
        end
    end

    logic                     w_en_q,   w_en_d;
    logic [ADDRESS_WIDTH-1:0] wadd_q,   wadd_d;
    logic [DATA_WIDTH-1:0]    dt_q,     dt_d;
    logic                     coll_q,   coll_d;
    logic                     sticky_q, sticky_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q,    cnt_d;

    always_comb begin
        w_en_d   = s0_valid;
        wadd_d   = s0_wadd;
        dt_d     = s0_dt;
        coll_d   = collision;
        sticky_d = (sticky_q | collision) & ~err_clr;
        cnt_d    = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (collision && (cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_q   <= 1'b0;
            wadd_q   <= '0;
            dt_q     <= '0;
            coll_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            w_en_q   <= w_en_d;
            wadd_q   <= wadd_d;
            dt_q     <= dt_d;
            coll_q   <= coll_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign xb_rf_w_En     = w_en_q;
    assign xb_rf_wadd     = wadd_q;
    assign xb_rf_dt       = dt_q;
    assign xb_coll        = coll_q;
    assign xb_coll_sticky = sticky_q;
    assign xb_coll_cnt    = cnt_q;

    xb_fwd_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .FWD_EN       (FWD_EN)
    ) u_fwd_x (
        .raddr_i   (ps_xb_raddx),
        .s0_valid_i(s0_valid),
        .s0_wadd_i (s0_wadd),
        .s0_dt_i   (s0_dt),
        .s1_valid_i(w_en_q),
        .s1_wadd_i (wadd_q),
        .s1_dt_i   (dt_q),
        .rf_dt_i   (rf_xb_dtx),
        .dt_o      (xb_dtx)
    );

    xb_fwd_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .FWD_EN       (FWD_EN)
    ) u_fwd_y (
        .raddr_i   (ps_xb_raddy),
        .s0_valid_i(s0_valid),
        .s0_wadd_i (s0_wadd),
        .s0_dt_i   (s0_dt),
        .s1_valid_i(w_en_q),
        .s1_wadd_i (wadd_q),
        .s1_dt_i   (dt_q),
        .rf_dt_i   (rf_xb_dty),
        .dt_o      (xb_dty)
    );

endmodule
